// File: rtl/reflet_int_to_float_seq_pkg.sv
// Shared float-format helpers for the reflet int/float converters.
// Optional macro REFLET_INT_TO_FLOAT_ROUND_EN selects round-to-nearest-even instead of truncation.
package reflet_int_to_float_seq_pkg;

`ifdef REFLET_INT_TO_FLOAT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  function automatic int exponent_size(input int float_size);
    if (float_size <= 16)      return 5;
    else if (float_size <= 32) return 8;
    else if (float_size <= 64) return 11;
    else                       return 15;
  endfunction

  function automatic int mantissa_size(input int float_size);
    return float_size - exponent_size(float_size) - 1;
  endfunction

  function automatic int exponent_bias(input int float_size);
    return (1 << (exponent_size(float_size) - 1)) - 1;
  endfunction

  function automatic int exponent_all_ones(input int float_size);
    return (1 << exponent_size(float_size)) - 1;
  endfunction

  // Unbiased exponent never exceeds int_size-1 and never goes negative.
  function automatic int exp_width(input int int_size);
    return $clog2(int_size);
  endfunction

endpackage

// File: rtl/reflet_int_to_float_pack.sv
// Combinational packer: normalised magnitude and exponent to a packed float word,
// with truncation or round-to-nearest-even and saturation to infinity.
module reflet_int_to_float_pack
  import reflet_int_to_float_seq_pkg::*;
#(
  parameter int int_size   = 16,
  parameter int float_size = 32,
  parameter int exp_w      = exp_width(int_size)
) (
  input  logic                  sign,
  input  logic [int_size-1:0]   m,
  input  logic [exp_w-1:0]      e,
  output logic [float_size-1:0] float_out
);

  localparam int ES       = exponent_size(float_size);
  localparam int MS       = mantissa_size(float_size);
  localparam int BIAS     = exponent_bias(float_size);
  localparam int ALL_ONES = exponent_all_ones(float_size);
  localparam int FW       = int_size - 1;

  logic [FW-1:0] frac;
  logic [MS-1:0] mant_trunc;
  logic          round_up;
  logic [MS:0]   mant_sum;
  logic [31:0]   biased;
  logic [31:0]   biased_r;
  logic          is_zero;

  assign frac    = m[FW-1:0];
  // A clear leading bit means the magnitude was zero: emit +0.
  assign is_zero = ~m[int_size-1];

  generate
    if (FW > MS) begin : g_trunc
      localparam int DW = FW - MS;
      logic [DW-1:0] disc;
      logic [DW-1:0] below_guard;
      assign mant_trunc  = frac[FW-1 -: MS];
      assign disc        = frac[DW-1:0];
      assign below_guard = disc << 1;
      assign round_up    = ROUND_EN & disc[DW-1] & ((|below_guard) | mant_trunc[0]);
    end else begin : g_pad
      assign mant_trunc = MS'(frac) << (MS - FW);
      assign round_up   = 1'b0;
    end
  endgenerate

  // Mantissa carry-out leaves the low MS bits at zero and bumps the exponent.
  assign mant_sum = {1'b0, mant_trunc} + {{MS{1'b0}}, round_up};
  assign biased   = 32'(e) + 32'(BIAS);
  assign biased_r = biased + {31'd0, mant_sum[MS]};

  always_comb begin
    float_out = '0;
    if (!is_zero) begin
      if (biased_r >= 32'(ALL_ONES)) begin
        float_out = {sign, ES'(ALL_ONES), {MS{1'b0}}};
      end else begin
        float_out = {sign, biased_r[ES-1:0], mant_sum[MS-1:0]};
      end
    end
  end

endmodule

// File: rtl/reflet_int_to_float_seq.sv
// Sequential signed-integer to float converter; normalises one bit per clock
// behind valid/ready handshakes on both sides.
module reflet_int_to_float_seq
  import reflet_int_to_float_seq_pkg::*;
#(
  parameter int int_size   = 16,
  parameter int float_size = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [int_size-1:0]   int_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [float_size-1:0] float_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int EW = exp_width(int_size);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  sign_q, sign_d;
  logic [int_size-1:0]   m_q, m_d;
  logic [EW-1:0]         e_q, e_d;
  logic [float_size-1:0] float_q, float_d;
  logic                  out_valid_q, out_valid_d;

  logic [int_size-1:0]   abs_in;
  logic [int_size-1:0]   m_shift;
  logic [EW-1:0]         e_dec;
  logic                  pack_sign;
  logic [int_size-1:0]   pack_m;
  logic [EW-1:0]         pack_e;
  logic [float_size-1:0] pack_out;

  // Unsigned negate: the most negative input maps to 2^(int_size-1) exactly.
  assign abs_in  = int_in[int_size-1] ? (-int_in) : int_in;
  assign m_shift = m_q << 1;
  assign e_dec   = e_q - EW'(1);

  // The packer sees the candidate value for this edge, so the edge that
  // finds the leading one also loads the result.
  always_comb begin
    pack_sign = sign_q;
    pack_m    = m_shift;
    pack_e    = e_dec;
    if (state_q == S_IDLE) begin
      pack_sign = int_in[int_size-1];
      pack_m    = abs_in;
      pack_e    = EW'(int_size - 1);
    end
  end

  reflet_int_to_float_pack #(
    .int_size  (int_size),
    .float_size(float_size),
    .exp_w     (EW)
  ) u_pack (
    .sign     (pack_sign),
    .m        (pack_m),
    .e        (pack_e),
    .float_out(pack_out)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    m_d         = m_q;
    e_d         = e_q;
    float_d     = float_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = int_in[int_size-1];
          m_d    = abs_in;
          e_d    = EW'(int_size - 1);
          if (abs_in[int_size-1] || (int_in == '0)) begin
            float_d     = pack_out;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        m_d = m_shift;
        e_d = e_dec;
        if (m_shift[int_size-1]) begin
          float_d     = pack_out;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      m_q         <= '0;
      e_q         <= '0;
      float_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      m_q         <= m_d;
      e_q         <= e_d;
      float_q     <= float_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign float_out = float_q;

endmodule
